// File: rtl/dwc_pkg.sv
// Shared helpers for the data-width converters (up-sizer and down-sizer).
// Element packing is done with a local typedef of the form
// logic [FOLD-1:0][ACTIVATION_WIDTH-1:0] inside each converter.
package dwc_pkg;

    // Number of narrow beats that make up one wide beat.
    function automatic int dwc_ratio(input int out_fold, input int in_fold);
        return out_fold / in_fold;
    endfunction

    // Beat-counter width; never below one bit, so RATIO == 1 still has a counter.
    function automatic int dwc_cnt_w(input int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

    // The wide fold must be a whole multiple of the narrow fold.
    function automatic bit dwc_fold_ok(input int out_fold, input int in_fold);
        return (in_fold > 0) && (out_fold >= in_fold) && ((out_fold % in_fold) == 0);
    endfunction

endpackage

// File: rtl/dwc_out_reg.sv
// Output register slice: holds one word plus its valid flag.
// A load always wins over a consume, so a word can be replaced in the
// same cycle that the previous one leaves.
module dwc_out_reg #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Capture a new word on load, otherwise drop valid once it is consumed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/dwc_upsizer.sv
// Width up-sizer: gathers RATIO narrow AXI-Stream beats (lowest first) and
// presents them as one wide beat. Non-completing beats are always taken;
// only the beat that completes a word waits for the output slot.
module dwc_upsizer
    import dwc_pkg::*;
#(
    parameter int ACTIVATION_WIDTH = 4,
    parameter int IN_FOLD          = 2,
    parameter int OUT_FOLD         = 10,
    parameter int IN_WIDTH         = ACTIVATION_WIDTH * IN_FOLD,
    parameter int OUT_WIDTH        = ACTIVATION_WIDTH * OUT_FOLD
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic [IN_WIDTH-1:0]  s_axis_input_tdata,
    input  logic                 s_axis_input_tvalid,
    output logic                 s_axis_input_tready,
    output logic [OUT_WIDTH-1:0] m_axis_output_tdata,
    output logic                 m_axis_output_tvalid,
    input  logic                 m_axis_output_tready
);

    localparam int RATIO = dwc_ratio(OUT_FOLD, IN_FOLD);
    localparam int CW    = dwc_cnt_w(RATIO);

    if (!dwc_fold_ok(OUT_FOLD, IN_FOLD)) begin : g_bad_fold
        $error("dwc_upsizer: OUT_FOLD must be an integer multiple of IN_FOLD");
    end

    typedef logic [IN_FOLD-1:0][ACTIVATION_WIDTH-1:0] in_beat_t;

    in_beat_t                w_beat;
    logic [OUT_WIDTH-1:0]    w_word;
    logic                    w_last;
    logic                    w_acc;
    logic                    w_load;
    logic                    w_out_vld;
    logic [CW-1:0]           r_cnt;
    logic                    r_rst_done;

    assign w_beat = s_axis_input_tdata;
    assign w_last = (r_cnt == CW'(RATIO - 1));

    // The completing beat needs a free (or freeing) output slot; the rest
    // only need reset to be fully released.
    assign s_axis_input_tready = r_rst_done & (!w_last | !w_out_vld | m_axis_output_tready);
    assign w_acc  = s_axis_input_tvalid & s_axis_input_tready;
    assign w_load = w_acc & w_last;

    // Keep tready low in the cycle reset is released.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_rst_done <= 1'b0;
        else           r_rst_done <= 1'b1;
    end

    // Beat counter: steps on every accepted beat, wraps after the last slot.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)  r_cnt <= '0;
        else if (w_acc) r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end

    if (RATIO > 1) begin : g_collect
        logic [RATIO-2:0][IN_WIDTH-1:0] r_buf;

        // Park each non-completing beat in the slot named by the counter.
        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                r_buf <= '0;
            end else begin
                for (int k = 0; k < RATIO - 1; k++) begin
                    if (w_acc && (r_cnt == CW'(k))) r_buf[k] <= w_beat;
                end
            end
        end

        // Completing beat goes straight into the top slot of the wide word.
        assign w_word = {w_beat, r_buf};
    end else begin : g_passthru
        assign w_word = w_beat;
    end

    dwc_out_reg #(
        .W (OUT_WIDTH)
    ) u_out_reg (
        .i_clk   (ap_clk),
        .i_rst_n (ap_rst_n),
        .i_load  (w_load),
        .i_data  (w_word),
        .i_ready (m_axis_output_tready),
        .o_valid (w_out_vld),
        .o_data  (m_axis_output_tdata)
    );

    assign m_axis_output_tvalid = w_out_vld;

endmodule
